// File: rtl/exp_host_sequencer_if.sv
// Host/core signal bundle for exp_host_sequencer.
// slave  = the sequencer itself; master = host stream source/sink plus core model.
interface exp_host_sequencer_if #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 512
);
  logic              cfg_multiply;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              exp_start;
  logic              exp_multiply;
  logic [OP_W-1:0]   exp_x;
  logic [OP_W-1:0]   exp_e;
  logic [OP_W-1:0]   exp_m;
  logic [OP_W-1:0]   exp_rmodm;
  logic [OP_W-1:0]   exp_r2modm;
  logic              exp_done;
  logic [OP_W-1:0]   exp_result;
  logic [31:0]       run_cycles;

  modport slave (
    input  cfg_multiply, in_valid, in_data, out_ready, exp_done, exp_result,
    output in_ready, out_valid, out_data, out_last, busy, exp_start, exp_multiply,
           exp_x, exp_e, exp_m, exp_rmodm, exp_r2modm, run_cycles
  );

  modport master (
    output cfg_multiply, in_valid, in_data, out_ready, exp_done, exp_result,
    input  in_ready, out_valid, out_data, out_last, busy, exp_start, exp_multiply,
           exp_x, exp_e, exp_m, exp_rmodm, exp_r2modm, run_cycles
  );
endinterface

// File: rtl/exp_host_sequencer.sv
// Host-side sequencer for the Montgomery exponentiation core.
// Loads x, e, m, Rmodm, R^2modm word-serially (LSW first), holds start until
// done, then streams the captured result back LSW first.
// Optional macro EXP_CYCLE_COUNT_EN adds a saturating RUN-cycle counter.
module exp_host_sequencer #(
  parameter int WORD_W = 32,
  parameter int OP_W   = 512
) (
  input logic                clk,
  input logic                resetn,
  exp_host_sequencer_if.slave bus
);
  localparam int NWORDS = OP_W / WORD_W;
  localparam int WIDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIDX_W-1:0] LAST_W  = WIDX_W'(NWORDS - 1);
  localparam logic [2:0]        LAST_OP = 3'd4;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [WIDX_W-1:0] r_widx;
  logic [WIDX_W-1:0] r_ridx;
  logic [2:0]        r_opidx;
  logic              r_start;
  logic              r_mult;
  logic [OP_W-1:0]   r_x, r_e, r_m, r_rm, r_r2, r_res;

  logic                          w_in_fire;
  logic                          w_last_word;
  logic                          w_load_done;
  logic [NWORDS-1:0][WORD_W-1:0] w_res_words;

  // New word enters at the top; after NWORDS shifts the first word is at the bottom.
  function automatic logic [OP_W-1:0] shift_in(input logic [OP_W-1:0] cur,
                                               input logic [WORD_W-1:0] w);
    logic [OP_W+WORD_W-1:0] t;
    t = {w, cur};
    return t[OP_W+WORD_W-1:WORD_W];
  endfunction

  assign w_in_fire   = bus.in_valid && bus.in_ready;
  assign w_last_word = (r_widx == LAST_W);
  assign w_load_done = w_in_fire && w_last_word && (r_opidx == LAST_OP);
  assign w_res_words = r_res;

  // Handshake outputs come only from registered state: no out_ready->in_ready
  // or exp_done->out_valid combinational path.
  assign bus.in_ready     = (r_state == S_LOAD);
  assign bus.out_valid    = (r_state == S_DRAIN);
  assign bus.out_last     = (r_state == S_DRAIN) && (r_ridx == LAST_W);
  assign bus.out_data     = w_res_words[r_ridx];
  assign bus.busy         = (r_state != S_LOAD) || (r_opidx != '0) || (r_widx != '0);
  assign bus.exp_start    = r_start;
  assign bus.exp_multiply = r_mult;
  assign bus.exp_x        = r_x;
  assign bus.exp_e        = r_e;
  assign bus.exp_m        = r_m;
  assign bus.exp_rmodm    = r_rm;
  assign bus.exp_r2modm   = r_r2;

  // Control FSM: word/operand counters, start handshake with the core, result drain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_LOAD;
      r_widx  <= '0;
      r_opidx <= '0;
      r_ridx  <= '0;
      r_start <= 1'b0;
      r_mult  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            if (r_opidx == '0 && r_widx == '0) r_mult <= bus.cfg_multiply;
            if (w_last_word) begin
              r_widx <= '0;
              if (r_opidx == LAST_OP) begin
                r_opidx <= '0;
                r_state <= S_RUN;
                r_start <= 1'b1;
              end else begin
                r_opidx <= r_opidx + 3'd1;
              end
            end else begin
              r_widx <= r_widx + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (bus.exp_done) begin
            r_start <= 1'b0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.out_ready) begin
            if (r_ridx == LAST_W) begin
              r_ridx  <= '0;
              r_state <= S_LOAD;
            end else begin
              r_ridx <= r_ridx + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  // Operand assembly; registers keep their contents until overwritten by a later load.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x  <= '0;
      r_e  <= '0;
      r_m  <= '0;
      r_rm <= '0;
      r_r2 <= '0;
    end else if (w_in_fire) begin
      case (r_opidx)
        3'd0:    r_x  <= shift_in(r_x,  bus.in_data);
        3'd1:    r_e  <= shift_in(r_e,  bus.in_data);
        3'd2:    r_m  <= shift_in(r_m,  bus.in_data);
        3'd3:    r_rm <= shift_in(r_rm, bus.in_data);
        default: r_r2 <= shift_in(r_r2, bus.in_data);
      endcase
    end
  end

  // Capture the core result only while running; done elsewhere is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                r_res <= '0;
    else if (r_state == S_RUN && bus.exp_done)  r_res <= bus.exp_result;
  end

`ifdef EXP_CYCLE_COUNT_EN
  logic [31:0] r_cyc;

  // Count RUN cycles (saturating); cleared as a new job starts, held otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                    r_cyc <= '0;
    else if (w_load_done)                           r_cyc <= '0;
    else if (r_state == S_RUN && r_cyc != '1)       r_cyc <= r_cyc + 32'd1;
  end

  assign bus.run_cycles = r_cyc;
`else
  assign bus.run_cycles = '0;
`endif

endmodule
